// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants: default widths, forwarding-select encoding
// and stage indices used by the forwarding scoreboard.
package cpu_pkg;
  localparam int CPU_DATA_W = 8;
  localparam int CPU_RA_W   = 2;
  localparam int FWD_SEL_W  = 4;

  localparam logic [FWD_SEL_W-1:0] FWD_RF  = 4'd0;
  localparam logic [FWD_SEL_W-1:0] STG_EX  = 4'd1;
  localparam logic [FWD_SEL_W-1:0] STG_MEM = 4'd2;
  localparam logic [FWD_SEL_W-1:0] STG_WB  = 4'd3;
endpackage

// File: rtl/fwd_src_sel.sv
// Per-operand forwarding select: youngest matching in-flight producer wins,
// otherwise the register-file value passes through.
module fwd_src_sel
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int RA_W   = CPU_RA_W,
  parameter int DEPTH  = 3
) (
  input  logic                    i_rd,
  input  logic [RA_W-1:0]         i_src,
  input  logic [DATA_W-1:0]       i_rf_data,
  input  logic [DEPTH-1:0]        i_vld,
  input  logic [DEPTH*RA_W-1:0]   i_dst,
  input  logic [DEPTH*DATA_W-1:0] i_stg_data,
  input  logic [DEPTH-1:0]        i_stg_ok,
  output logic [DATA_W-1:0]       o_opnd,
  output logic [FWD_SEL_W-1:0]    o_fwd_sel,
  output logic                    o_hazard
);

  // Scan oldest to youngest so the lowest matching stage overrides the rest.
  always_comb begin
    o_opnd    = i_rf_data;
    o_fwd_sel = FWD_RF;
    o_hazard  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (i_rd && i_vld[k-1] && (i_dst[(k-1)*RA_W +: RA_W] == i_src)) begin
        o_opnd    = i_stg_data[(k-1)*DATA_W +: DATA_W];
        o_fwd_sel = FWD_SEL_W'(k);
        o_hazard  = ~i_stg_ok[k-1];
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and load-use hazard scoreboard over DEPTH in-flight
// stages, with a saturating stall-cycle counter.
module fwd_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int RA_W    = CPU_RA_W,
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        adv,
  input  logic                        flush,
  input  logic                        id_valid,
  input  logic                        id_we,
  input  logic [RA_W-1:0]             id_dest,
  input  logic [NUM_SRC*RA_W-1:0]     id_src,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0]   rf_data,
  input  logic [DEPTH*DATA_W-1:0]     stg_data,
  input  logic [DEPTH-1:0]            stg_data_ok,
  output logic [NUM_SRC*DATA_W-1:0]   opnd,
  output logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel,
  output logic                        stall,
  output logic [CNT_W-1:0]            stall_cnt
);

  logic [DEPTH-1:0]      r_vld;
  logic [DEPTH*RA_W-1:0] r_dst;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_SRC-1:0]    w_hazard;
  logic                  w_stall;
  logic                  w_load;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_sel #(
      .DATA_W (DATA_W),
      .RA_W   (RA_W),
      .DEPTH  (DEPTH)
    ) u_sel (
      .i_rd       (id_valid & id_src_used[g]),
      .i_src      (id_src[g*RA_W +: RA_W]),
      .i_rf_data  (rf_data[g*DATA_W +: DATA_W]),
      .i_vld      (r_vld),
      .i_dst      (r_dst),
      .i_stg_data (stg_data),
      .i_stg_ok   (stg_data_ok),
      .o_opnd     (opnd[g*DATA_W +: DATA_W]),
      .o_fwd_sel  (fwd_sel[g*FWD_SEL_W +: FWD_SEL_W]),
      .o_hazard   (w_hazard[g])
    );
  end

  assign w_stall   = |w_hazard;
  assign stall     = w_stall;
  assign stall_cnt = r_cnt;
  // A stalled or flushed decode slot enters stage 1 as a bubble.
  assign w_load    = id_valid & id_we & ~w_stall & ~flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= '0;
    end else if (adv) begin
      for (int k = DEPTH - 1; k >= 1; k--) r_vld[k] <= r_vld[k-1];
      r_vld[0] <= w_load;
    end
  end

  // Tags are qualified by r_vld, so they need no reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = DEPTH - 1; k >= 1; k--) r_dst[k*RA_W +: RA_W] <= r_dst[(k-1)*RA_W +: RA_W];
      r_dst[0 +: RA_W] <= id_dest;
    end
  end

  // A flush overrides the stall on that edge, so it is not counted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (adv && w_stall && !flush && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (DEPTH=3, NUM_SRC=2, CNT_W=4).
module tb_fwd_scoreboard;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        adv;
  logic        flush;
  logic        id_valid;
  logic        id_we;
  logic [1:0]  id_dest;
  logic [3:0]  id_src;
  logic [1:0]  id_src_used;
  logic [15:0] rf_data;
  logic [23:0] stg_data;
  logic [2:0]  stg_data_ok;
  logic [15:0] opnd;
  logic [7:0]  fwd_sel;
  logic        stall;
  logic [3:0]  stall_cnt;

  int n_pass = 0;
  int n_tot  = 0;
  logic [3:0] exp_cnt;

  fwd_scoreboard #(
    .DATA_W(8), .RA_W(2), .DEPTH(3), .NUM_SRC(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rstn(rstn), .adv(adv), .flush(flush),
    .id_valid(id_valid), .id_we(id_we), .id_dest(id_dest),
    .id_src(id_src), .id_src_used(id_src_used), .rf_data(rf_data),
    .stg_data(stg_data), .stg_data_ok(stg_data_ok),
    .opnd(opnd), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic we, input logic [1:0] d,
                     input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] used);
    id_valid    = v;
    id_we       = we;
    id_dest     = d;
    id_src      = {s1, s0};
    id_src_used = used;
  endtask

  task automatic pipe_clear();
    drv(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'b00);
    adv = 1'b1; flush = 1'b0; stg_data_ok = 3'b111;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; adv = 1'b1; flush = 1'b0; stg_data_ok = 3'b000;
    rf_data = {8'd99, 8'd77}; stg_data = {8'd33, 8'd22, 8'd11};
    drv(1'b1, 1'b1, 2'd1, 2'd1, 2'd1, 2'b11);
    #2;
    n_tot++; if (stall !== 1'b0) $display("FAIL rst_stall got %0b want 0", stall); else n_pass++;
    n_tot++; if (fwd_sel !== {FWD_RF, FWD_RF}) $display("FAIL rst_sel got %h want 00", fwd_sel); else n_pass++;
    n_tot++; if (opnd !== 16'h634D) $display("FAIL rst_opnd got %h want 634d", opnd); else n_pass++;
    n_tot++; if (stall_cnt !== 4'd0) $display("FAIL rst_cnt got %0d want 0", stall_cnt); else n_pass++;
    #1 rstn = 1'b1;
    exp_cnt = 4'd0;
  endtask

  task automatic test_back_to_back();
    pipe_clear();
    stg_data = {8'd33, 8'd20, 8'd40};
    drv(1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'b00); tick();
    drv(1'b1, 1'b1, 2'd1, 2'd0, 2'd0, 2'b00); tick();
    drv(1'b1, 1'b1, 2'd1, 2'd1, 2'd0, 2'b11); #1;
    n_tot++; if (fwd_sel[3:0] !== STG_EX) $display("FAIL b2b_sel0 got %0d want 1", fwd_sel[3:0]); else n_pass++;
    n_tot++; if (opnd[7:0] !== 8'd40) $display("FAIL b2b_opnd0 got %0d want 40", opnd[7:0]); else n_pass++;
    n_tot++; if (fwd_sel[7:4] !== STG_MEM) $display("FAIL b2b_sel1 got %0d want 2", fwd_sel[7:4]); else n_pass++;
    n_tot++; if (opnd[15:8] !== 8'd20) $display("FAIL b2b_opnd1 got %0d want 20", opnd[15:8]); else n_pass++;
    n_tot++; if (stall !== 1'b0) $display("FAIL b2b_stall got %0b want 0", stall); else n_pass++;
  endtask

  task automatic test_youngest();
    pipe_clear();
    stg_data = {8'd40, 8'd50, 8'd60};
    drv(1'b1, 1'b1, 2'd1, 2'd0, 2'd0, 2'b00); tick();
    drv(1'b1, 1'b1, 2'd2, 2'd0, 2'd0, 2'b00); tick();
    drv(1'b1, 1'b1, 2'd1, 2'd0, 2'd0, 2'b00); tick();
    drv(1'b1, 1'b0, 2'd0, 2'd1, 2'd3, 2'b11); #1;
    n_tot++; if (fwd_sel[3:0] !== STG_EX) $display("FAIL young_sel0 got %0d want 1", fwd_sel[3:0]); else n_pass++;
    n_tot++; if (opnd[7:0] !== 8'd60) $display("FAIL young_opnd0 got %0d want 60", opnd[7:0]); else n_pass++;
    n_tot++; if (fwd_sel[7:4] !== FWD_RF) $display("FAIL young_sel1 got %0d want 0", fwd_sel[7:4]); else n_pass++;
    n_tot++; if (opnd[15:8] !== 8'd99) $display("FAIL young_opnd1 got %0d want 99", opnd[15:8]); else n_pass++;
  endtask

  task automatic test_load_use();
    pipe_clear();
    stg_data = {8'd33, 8'd22, 8'd11};
    drv(1'b1, 1'b1, 2'd2, 2'd0, 2'd0, 2'b00); tick();
    stg_data_ok = 3'b110;
    drv(1'b1, 1'b1, 2'd3, 2'd2, 2'd3, 2'b01); #1;
    n_tot++; if (stall !== 1'b1) $display("FAIL lu_stall got %0b want 1", stall); else n_pass++;
    n_tot++; if (fwd_sel[3:0] !== STG_EX) $display("FAIL lu_sel0 got %0d want 1", fwd_sel[3:0]); else n_pass++;
    n_tot++; if (opnd[7:0] !== 8'd11) $display("FAIL lu_opnd0 got %0d want 11", opnd[7:0]); else n_pass++;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    stg_data_ok = 3'b111;
    id_src_used = 2'b11; #1;
    n_tot++; if (fwd_sel[3:0] !== STG_MEM) $display("FAIL lu_next_sel0 got %0d want 2", fwd_sel[3:0]); else n_pass++;
    n_tot++; if (opnd[7:0] !== 8'd22) $display("FAIL lu_next_opnd0 got %0d want 22", opnd[7:0]); else n_pass++;
    n_tot++; if (stall !== 1'b0) $display("FAIL lu_next_stall got %0b want 0", stall); else n_pass++;
    n_tot++; if (fwd_sel[7:4] !== FWD_RF) $display("FAIL lu_bubble_sel1 got %0d want 0", fwd_sel[7:4]); else n_pass++;
    n_tot++; if (stall_cnt !== exp_cnt) $display("FAIL lu_cnt got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
  endtask

  task automatic test_freeze_flush();
    pipe_clear();
    drv(1'b1, 1'b1, 2'd2, 2'd0, 2'd0, 2'b00); tick();
    stg_data_ok = 3'b110;
    drv(1'b1, 1'b1, 2'd3, 2'd2, 2'd3, 2'b01);
    adv = 1'b0;
    repeat (3) tick();
    n_tot++; if (stall !== 1'b1) $display("FAIL frz_stall got %0b want 1", stall); else n_pass++;
    n_tot++; if (fwd_sel[3:0] !== STG_EX) $display("FAIL frz_sel0 got %0d want 1", fwd_sel[3:0]); else n_pass++;
    n_tot++; if (stall_cnt !== exp_cnt) $display("FAIL frz_cnt got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
    adv = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; stg_data_ok = 3'b111; id_src_used = 2'b11; #1;
    n_tot++; if (fwd_sel[3:0] !== STG_MEM) $display("FAIL fl_sel0 got %0d want 2", fwd_sel[3:0]); else n_pass++;
    n_tot++; if (fwd_sel[7:4] !== FWD_RF) $display("FAIL fl_bubble_sel1 got %0d want 0", fwd_sel[7:4]); else n_pass++;
    n_tot++; if (stall_cnt !== exp_cnt) $display("FAIL fl_cnt got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
  endtask

  task automatic test_unused();
    pipe_clear();
    drv(1'b1, 1'b1, 2'd1, 2'd0, 2'd0, 2'b00); tick();
    stg_data_ok = 3'b110;
    drv(1'b1, 1'b0, 2'd0, 2'd1, 2'd1, 2'b00); #1;
    n_tot++; if (fwd_sel[3:0] !== FWD_RF) $display("FAIL unused_sel0 got %0d want 0", fwd_sel[3:0]); else n_pass++;
    n_tot++; if (opnd[7:0] !== 8'd77) $display("FAIL unused_opnd0 got %0d want 77", opnd[7:0]); else n_pass++;
    n_tot++; if (stall !== 1'b0) $display("FAIL unused_stall got %0b want 0", stall); else n_pass++;
    drv(1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'b11); #1;
    n_tot++; if (fwd_sel[7:4] !== FWD_RF) $display("FAIL novalid_sel1 got %0d want 0", fwd_sel[7:4]); else n_pass++;
    n_tot++; if (stall !== 1'b0) $display("FAIL novalid_stall got %0b want 0", stall); else n_pass++;
  endtask

  task automatic sat_round();
    drv(1'b1, 1'b1, 2'd2, 2'd0, 2'd0, 2'b00); tick();
    drv(1'b1, 1'b0, 2'd0, 2'd2, 2'd0, 2'b01);
    repeat (3) tick();
  endtask

  task automatic test_saturation();
    pipe_clear();
    stg_data_ok = 3'b000;
    #1 rstn = 1'b0;
    #1 rstn = 1'b1;
    n_tot++; if (stall_cnt !== 4'd0) $display("FAIL sat_start got %0d want 0", stall_cnt); else n_pass++;
    repeat (4) sat_round();
    n_tot++; if (stall_cnt !== 4'd12) $display("FAIL sat_12 got %0d want 12", stall_cnt); else n_pass++;
    sat_round();
    n_tot++; if (stall_cnt !== 4'd15) $display("FAIL sat_15 got %0d want 15", stall_cnt); else n_pass++;
    repeat (2) sat_round();
    n_tot++; if (stall_cnt !== 4'd15) $display("FAIL sat_hold got %0d want 15", stall_cnt); else n_pass++;
  endtask

  task automatic test_reset_midop();
    pipe_clear();
    stg_data = {8'd33, 8'd22, 8'd11};
    repeat (3) begin
      drv(1'b1, 1'b1, 2'd1, 2'd0, 2'd0, 2'b00); tick();
    end
    stg_data_ok = 3'b110;
    drv(1'b1, 1'b0, 2'd0, 2'd1, 2'd1, 2'b11); #1;
    n_tot++; if (stall !== 1'b1) $display("FAIL pre_rst_stall got %0b want 1", stall); else n_pass++;
    #1 rstn = 1'b0;
    #1;
    n_tot++; if (stall !== 1'b0) $display("FAIL mrst_stall got %0b want 0", stall); else n_pass++;
    n_tot++; if (fwd_sel !== {FWD_RF, FWD_RF}) $display("FAIL mrst_sel got %h want 00", fwd_sel); else n_pass++;
    n_tot++; if (opnd !== 16'h634D) $display("FAIL mrst_opnd got %h want 634d", opnd); else n_pass++;
    n_tot++; if (stall_cnt !== 4'd0) $display("FAIL mrst_cnt got %0d want 0", stall_cnt); else n_pass++;
    #1 rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_youngest();
    test_load_use();
    test_freeze_flush();
    test_unused();
    test_saturation();
    test_reset_midop();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
